// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle main controller and the CPU datapath.
// master: controller side (drives strobes/selects, observes IR opcode and flags).
// slave : datapath side.
interface multicycle_control_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] aluOp;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;

    modport master (
        input  opcode, zero, mem_ready,
        output aluOp, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               iord, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  aluOp, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               iord, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the 16-bit CPU (feeds ALU_Control via aluOp).
// Sequences fetch/decode/execute/memory/write-back, stalls on mem_ready and
// counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes enter a sticky TRAP
// state); when undefined, illegal opcodes are NOPs and trap is tied to 0.
module multicycle_control #(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_control_if.master    bus,
    output logic [3:0]              state,
    output logic [RETIRE_W-1:0]     instr_count,
    output logic                    trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
`ifdef ILLEGAL_TRAP_EN
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
`else
        S_JUMP     = 4'd11
`endif
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire_c;

    // zero only qualifies pc_write_cond inside the datapath
    logic unused_zero;
    assign unused_zero = bus.zero;

    assign state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Retired-instruction counter, wraps modulo 2^RETIRE_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        instr_count <= '0;
        else if (retire_c) instr_count <= instr_count + RETIRE_W'(1);
    end

    // Next-state and Moore output decode; handshake strobes gated by mem_ready
    always_comb begin
        state_d           = S_FETCH;
        retire_c          = 1'b0;
        trap              = 1'b0;
        bus.aluOp         = 3'b000;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_source     = 2'b00;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.aluOp     = 3'b001;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b10;
                bus.aluOp     = 3'b001;
                case (bus.opcode)
                    4'b0000:                                  state_d = S_EXEC_R;
                    4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1001: state_d = S_EXEC_I;
                    4'b0101, 4'b0110:                         state_d = S_MEM_ADDR;
                    4'b0111:                                  state_d = S_BRANCH;
                    4'b1000:                                  state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:                                  state_d = S_TRAP;
`else
                    default:                                  state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.aluOp     = 3'b001;
                if (bus.opcode == 4'b0110)      state_d = S_MEM_WR;
                else if (bus.opcode == 4'b0101) state_d = S_MEM_RD;
                else                            state_d = S_FETCH;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                state_d      = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire_c       = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                retire_c      = bus.mem_ready;
                state_d       = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire_c      = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                state_d       = S_I_WB;
                case (bus.opcode)
                    4'b0001: begin bus.aluOp = 3'b001; bus.alu_src_b = 2'b10; end
                    4'b0010: begin bus.aluOp = 3'b011; bus.alu_src_b = 2'b11; end
                    4'b0011: begin bus.aluOp = 3'b100; bus.alu_src_b = 2'b11; end
                    4'b0100: begin bus.aluOp = 3'b101; bus.alu_src_b = 2'b10; end
                    4'b1001: begin bus.aluOp = 3'b110; bus.alu_src_b = 2'b11; end
                    default: begin bus.aluOp = 3'b000; bus.alu_src_b = 2'b00; end
                endcase
            end
            S_I_WB: begin
                bus.reg_write = 1'b1;
                retire_c      = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.aluOp         = 3'b010;
                bus.pc_source     = 2'b01;
                bus.pc_write_cond = 1'b1;
                retire_c          = 1'b1;
            end
            S_JUMP: begin
                bus.pc_source = 2'b10;
                bus.pc_write  = 1'b1;
                retire_c      = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // Reset holds every strobe and select low, not just the state
        if (!rst_n) begin
            retire_c          = 1'b0;
            trap              = 1'b0;
            bus.aluOp         = 3'b000;
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.iord          = 1'b0;
            bus.reg_write     = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = 2'b00;
            bus.pc_source     = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (narrow counter so the
// wrap test stays short). Outputs are sampled 1 time unit after the falling edge.
module tb_multicycle_control;
    localparam int unsigned TB_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      state;
    logic [TB_W-1:0] instr_count;
    logic            trap;
    logic [TB_W-1:0] exp_count;
    int              errors = 0;
    int              checks = 0;

    multicycle_control_if bus();

    multicycle_control #(.RETIRE_W(TB_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .state       (state),
        .instr_count (instr_count),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] LW_ST [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    localparam logic       LW_MR [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [3:0] SW_ST [5]  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    localparam logic       SW_MR [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [3:0] R_ST  [4]  = '{4'd0, 4'd1, 4'd6, 4'd7};
    localparam logic [3:0] I_OP  [5]  = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1001};
    localparam logic [2:0] I_ALU [5]  = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
    localparam logic [1:0] I_SRB [5]  = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11};

    // {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write,
    //  reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], pc_source[1:0], aluOp[2:0]}
    function automatic logic [16:0] obs_all();
        return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.iord, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.pc_source, bus.aluOp};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bus.mem_ready = 1'b1; bus.opcode = 4'b0000; bus.zero = 1'b0;
        @(negedge clk); #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (obs_all() !== 17'd0) begin errors++; $display("FAIL reset_outputs got=%b want=0", obs_all()); end
        checks++; if (instr_count !== '0) begin errors++; $display("FAIL reset_count got=%0d want=0", instr_count); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got=%b want=0", trap); end
        rst_n = 1'b1; #1;
        checks++; if (obs_all() !== 17'b1011000000_01_00_001) begin errors++; $display("FAIL release_fetch got=%b want=%b", obs_all(), 17'b1011000000_01_00_001); end
        bus.mem_ready = 1'b0; #1;
        checks++; if (obs_all() !== 17'b0001000000_01_00_001) begin errors++; $display("FAIL fetch_stall got=%b want=%b", obs_all(), 17'b0001000000_01_00_001); end
        exp_count = '0;
    endtask

    task automatic test_rtype();
        bus.opcode = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.mem_ready = 1'b1; #1;
            checks++; if (state !== R_ST[i]) begin errors++; $display("FAIL rtype_state[%0d] got=%0d want=%0d", i, state, R_ST[i]); end
            if (i == 2) begin
                checks++; if ({bus.aluOp, bus.alu_src_a, bus.alu_src_b} !== 6'b000_1_00) begin errors++; $display("FAIL rtype_exec got=%b want=000100", {bus.aluOp, bus.alu_src_a, bus.alu_src_b}); end
            end
            if (i == 3) begin
                checks++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110) begin errors++; $display("FAIL rtype_wb got=%b want=110", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
            end
        end
        exp_count = exp_count + 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0 || instr_count !== exp_count) begin errors++; $display("FAIL rtype_retire state=%0d count=%0d want state=0 count=%0d", state, instr_count, exp_count); end
    endtask

    task automatic test_lw_wait();
        int pulses = 0;
        bus.opcode = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus.mem_ready = LW_MR[i]; #1;
            pulses += int'(bus.ir_write);
            checks++; if (state !== LW_ST[i]) begin errors++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, LW_ST[i]); end
            if (LW_ST[i] == 4'd3) begin
                checks++; if ({bus.mem_read, bus.iord} !== 2'b11) begin errors++; $display("FAIL lw_memrd[%0d] got=%b want=11", i, {bus.mem_read, bus.iord}); end
            end
            if (LW_ST[i] == 4'd4) begin
                checks++; if ({bus.reg_write, bus.mem_to_reg, bus.reg_dst} !== 3'b110) begin errors++; $display("FAIL lw_wb got=%b want=110", {bus.reg_write, bus.mem_to_reg, bus.reg_dst}); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL lw_ir_write_pulses got=%0d want=1", pulses); end
        exp_count = exp_count + 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0 || instr_count !== exp_count) begin errors++; $display("FAIL lw_retire state=%0d count=%0d want state=0 count=%0d", state, instr_count, exp_count); end
    endtask

    task automatic test_sw_wait();
        bus.opcode = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus.mem_ready = SW_MR[i]; #1;
            checks++; if (state !== SW_ST[i]) begin errors++; $display("FAIL sw_state[%0d] got=%0d want=%0d", i, state, SW_ST[i]); end
            if (SW_ST[i] == 4'd5) begin
                checks++; if ({bus.mem_write, bus.iord, bus.mem_read} !== 3'b110) begin errors++; $display("FAIL sw_memwr[%0d] got=%b want=110", i, {bus.mem_write, bus.iord, bus.mem_read}); end
            end
        end
        checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL sw_early_retire got=%0d want=%0d", instr_count, exp_count); end
        exp_count = exp_count + 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0 || instr_count !== exp_count) begin errors++; $display("FAIL sw_retire state=%0d count=%0d want state=0 count=%0d", state, instr_count, exp_count); end
    endtask

    task automatic test_beq();
        bus.opcode = 4'b0111;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); bus.mem_ready = 1'b1; #1;
                checks++; if (state !== ((i == 2) ? 4'd10 : 4'(i))) begin errors++; $display("FAIL beq%0d_state[%0d] got=%0d", z, i, state); end
                if (i == 2) begin
                    checks++; if ({bus.aluOp, bus.pc_source, bus.pc_write_cond, bus.pc_write, bus.alu_src_a} !== 8'b010_01_1_0_1) begin
                        errors++; $display("FAIL beq%0d_ctrl got=%b want=01001101", z, {bus.aluOp, bus.pc_source, bus.pc_write_cond, bus.pc_write, bus.alu_src_a});
                    end
                end
            end
            exp_count = exp_count + 1'b1;
            @(negedge clk); bus.mem_ready = 1'b0; #1;
            checks++; if (state !== 4'd0 || instr_count !== exp_count) begin errors++; $display("FAIL beq%0d_retire state=%0d count=%0d want state=0 count=%0d", z, state, instr_count, exp_count); end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_itype();
        for (int k = 0; k < 5; k++) begin
            bus.opcode = I_OP[k];
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); bus.mem_ready = 1'b1; #1;
                checks++; if (state !== ((i >= 2) ? 4'(i + 6) : 4'(i))) begin errors++; $display("FAIL itype%0d_state[%0d] got=%0d", k, i, state); end
                if (i == 2) begin
                    checks++; if ({bus.aluOp, bus.alu_src_b, bus.alu_src_a} !== {I_ALU[k], I_SRB[k], 1'b1}) begin
                        errors++; $display("FAIL itype%0d_exec got=%b want=%b", k, {bus.aluOp, bus.alu_src_b, bus.alu_src_a}, {I_ALU[k], I_SRB[k], 1'b1});
                    end
                end
                if (i == 3) begin
                    checks++; if ({bus.reg_write, bus.reg_dst} !== 2'b10) begin errors++; $display("FAIL itype%0d_wb got=%b want=10", k, {bus.reg_write, bus.reg_dst}); end
                end
            end
            exp_count = exp_count + 1'b1;
            @(negedge clk); bus.mem_ready = 1'b0; #1;
            checks++; if (state !== 4'd0 || instr_count !== exp_count) begin errors++; $display("FAIL itype%0d_retire state=%0d count=%0d want count=%0d", k, state, instr_count, exp_count); end
        end
    endtask

    task automatic test_reset_mid();
        bus.opcode = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.mem_ready = 1'b1;
        end
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd3 || instr_count !== exp_count) begin errors++; $display("FAIL rstmid_pre state=%0d count=%0d want state=3 count=%0d", state, instr_count, exp_count); end
        @(posedge clk); #2; rst_n = 1'b0; #1;
        checks++; if (state !== 4'd0 || instr_count !== '0) begin errors++; $display("FAIL rstmid_async state=%0d count=%0d want 0/0", state, instr_count); end
        checks++; if (obs_all() !== 17'd0) begin errors++; $display("FAIL rstmid_outputs got=%b want=0", obs_all()); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (state !== 4'd0 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL rstmid_release state=%0d mem_read=%b want 0/1", state, bus.mem_read); end
        exp_count = '0;
    endtask

    task automatic test_illegal_wrap();
        bus.opcode = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.mem_ready = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (state !== 4'd12 || trap !== 1'b1 || obs_all() !== 17'd0 || instr_count !== exp_count) begin
                errors++; $display("FAIL trap_hold[%0d] state=%0d trap=%b outs=%b count=%0d", i, state, trap, obs_all(), instr_count);
            end
        end
`else
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0 || trap !== 1'b0 || instr_count !== exp_count) begin
            errors++; $display("FAIL illegal_nop state=%0d trap=%b count=%0d want 0/0/%0d", state, trap, instr_count, exp_count);
        end
`endif
        @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1; exp_count = '0;
        bus.opcode = 4'b1000;
        for (int n = 0; n < (1 << TB_W) + 1; n++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); bus.mem_ready = 1'b1; #1;
                if (i == 2) begin
                    checks++; if (state !== 4'd11 || {bus.pc_write, bus.pc_source} !== 3'b110) begin
                        errors++; $display("FAIL jmp%0d_ctrl state=%0d got=%b want=110", n, state, {bus.pc_write, bus.pc_source});
                    end
                end
            end
            exp_count = exp_count + 1'b1;
            @(negedge clk); bus.mem_ready = 1'b0; #1;
            checks++; if (state !== 4'd0 || instr_count !== exp_count) begin errors++; $display("FAIL jmp%0d_count state=%0d got=%0d want=%0d", n, state, instr_count, exp_count); end
        end
        checks++; if (instr_count !== TB_W'(1)) begin errors++; $display("FAIL wrap_final got=%0d want=1", instr_count); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_wait();
        test_beq();
        test_itype();
        test_reset_mid();
        test_illegal_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the 16-bit CPU; sits directly upstream of ALU_Control.
- Decodes the 4-bit opcode from the instruction register and sequences fetch, decode, execute, memory and write-back.
- Drives aluOp[2:0] to ALU_Control; ALU_Control turns it into aluCtr.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- RETIRE_W, 16, width of the retired-instruction counter instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4  IR[15:12].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- aluOp  out  3  to ALU_Control. 000 R-type (use func), 001 add, 010 sub, 011 and, 100 or, 101 slt, 110 pass-B, 111 unused.
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath strobes/selects.
- alu_src_b  out  2  00 regB, 01 const 1, 10 sign-ext imm, 11 zero-ext imm.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state code, for debug.
- instr_count  out  RETIRE_W  retired-instruction count.
- trap  out  1  illegal-opcode trap (only with the optional feature).

Behaviour:
- State codes:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, TRAP=12.
  - Codes 13-15 go to FETCH on the next clock.
- Reset:
  - rst_n=0 immediately forces state=FETCH, instr_count=0, trap=0.
  - While reset is low, all strobes and selects are forced to 0, aluOp=000.
  - The first edge after release evaluates FETCH.
- Outputs are a Moore decode of state, except the handshake-gated strobes, which are ANDed with mem_ready. Any signal not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluOp=001, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=10, aluOp=001 (branch target precompute).
  - Next state by opcode: 0000 EXEC_R; 0001-0100 and 1001 EXEC_I; 0101/0110 MEM_ADDR; 0111 BRANCH; 1000 JUMP; 1010-1111 illegal.
- MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, aluOp=001.
  - Opcode 0101 goes to MEM_RD; opcode 0110 goes to MEM_WR.
- MEM_RD:
  - mem_read=1, iord=1.
  - Hold until mem_ready, then go to MEM_WB.
- MEM_WB:
  - reg_write=1, mem_to_reg=1, reg_dst=0.
  - Retires; go to FETCH.
- MEM_WR:
  - mem_write=1, iord=1.
  - Hold until mem_ready; retires on the handshake cycle; go to FETCH.
  - mem_write stays asserted throughout the wait.
- EXEC_R:
  - alu_src_a=1, alu_src_b=00, aluOp=000.
  - Go to R_WB.
- R_WB:
  - reg_write=1, reg_dst=1.
  - Retires; go to FETCH.
- EXEC_I:
  - alu_src_a=1.
  - Opcode 0001: aluOp=001, alu_src_b=10.
  - Opcode 0010: aluOp=011, alu_src_b=11.
  - Opcode 0011: aluOp=100, alu_src_b=11.
  - Opcode 0100: aluOp=101, alu_src_b=10.
  - Opcode 1001: aluOp=110, alu_src_b=11.
  - Go to I_WB.
- I_WB:
  - reg_write=1, reg_dst=0.
  - Retires; go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, aluOp=010, pc_source=01, pc_write_cond=1.
  - The PC updates when zero=1.
  - Retires; go to FETCH.
- JUMP:
  - pc_source=10, pc_write=1.
  - Retires; go to FETCH.
- Illegal opcode without the optional feature: go from DECODE to FETCH with no retire (treated as NOP).
- Retire events:
  - instr_count increments by 1 on the clock edge leaving a retiring state.
  - The counter wraps modulo 2^RETIRE_W and never saturates.
- Latency in cycles, assuming mem_ready is already high:
  - R-type 4, I-type 4, lw 5, sw 4, beq 3, jmp 3.
  - Each mem_ready=0 cycle adds exactly 1 cycle.
- opcode is sampled in DECODE and all later states. The IR is stable after FETCH, so opcode changes while in FETCH are ignored.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP drives trap=1 with all strobes 0 and holds until rst_n=0.
  - instr_count is frozen while in TRAP.
- Undefined:
  - There is no TRAP state or logic; the trap port is tied to 0.
  - An illegal opcode acts as a NOP (DECODE to FETCH).

Test Plan:
- Reset mid-operation:
  - Stimulus: drive rst_n=0 asynchronously while in MEM_RD.
  - Response: state=0, all strobes 0 and instr_count=0 before the next clock edge. After release, FETCH with mem_read=1.
- R-type with mem_ready=1:
  - Stimulus: opcode=0000.
  - Response: state sequence 0,1,6,7,0. aluOp=000 in EXEC_R; reg_write=1 and reg_dst=1 in R_WB; instr_count goes 0 to 1.
- lw with wait states:
  - Stimulus: opcode=0101, mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEM_RD.
  - Response: total 10 cycles. ir_write pulses exactly once; mem_read and iord stay high through the MEM_RD wait.
- beq:
  - Stimulus: opcode=0111, first with zero=1, then with zero=0.
  - Response: both cases take 3 cycles with aluOp=010, pc_source=01, pc_write_cond=1 in BRANCH, and both retire.
- I-type sweep:
  - Stimulus: opcodes 0001, 0010, 0011, 0100, 1001.
  - Response: EXEC_I aluOp is 001/011/100/101/110 and alu_src_b is 10/11/11/10/11 respectively.
- Illegal opcode and counter wrap:
  - Stimulus: opcode=1111, then 2^RETIRE_W+1 jmp instructions (1000).
  - Response with ILLEGAL_TRAP_EN: the 1111 enters TRAP with trap=1 held and the count frozen, so run the jmp sequence from a fresh reset.
  - Response without ILLEGAL_TRAP_EN: the 1111 returns to FETCH with no count change; instr_count wraps to 1 after the jmp sequence.
